// File: rtl/timer_alarm_defs.sv
// Shared encodings for the alarm FSM; the status register reuses these
// so software sees the same values as state_o.
package timer_alarm_defs;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/iob_counter_sat.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module iob_counter_sat #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         cke_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_cnt <= '0;
        end else if (cke_i) begin
            if (clr_i) begin
                r_cnt <= '0;
            end else if (inc_i && (r_cnt != {W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/timer_alarm.sv
// Compare/alarm stage beside the free-running timer: one-shot or periodic
// alarm with auto-reload, level irq and a saturating missed-alarm count.
//
// state   | meaning
// IDLE    | not armed; match and ack ignored
// ARMED   | waiting for timer_value_i >= compare point
// PENDING | irq asserted until acknowledged
module timer_alarm
    import timer_alarm_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int MISS_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                cke_i,
    input  logic [2*DATA_W-1:0] timer_value_i,
    input  logic                timer_en_i,
    input  logic [2*DATA_W-1:0] cfg_cmp_i,
    input  logic [2*DATA_W-1:0] cfg_period_i,
    input  logic                cfg_periodic_i,
    input  logic                arm_i,
    input  logic                disarm_i,
    input  logic                irq_ack_i,
    output logic                irq_o,
    output logic [STATE_W-1:0]  state_o,
    output logic [2*DATA_W-1:0] next_cmp_o,
    output logic [MISS_W-1:0]   missed_o
);

    alarm_state_e        r_state;
    logic                r_irq;
    logic                r_periodic;
    logic [2*DATA_W-1:0] r_cmp;

    logic w_match;
    logic w_period_zero;
    logic w_miss_inc;
    logic w_miss_clr;

    assign w_match       = timer_en_i && (timer_value_i >= r_cmp);
    assign w_period_zero = (cfg_period_i == '0);

    // A zero period degrades to one-shot at reload, so it never counts a miss.
    assign w_miss_inc = !disarm_i && !arm_i && !irq_ack_i && w_match &&
                        (r_state == ST_PENDING) && r_periodic && !w_period_zero;
    assign w_miss_clr = !disarm_i && arm_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= ST_IDLE;
            r_irq      <= 1'b0;
            r_periodic <= 1'b0;
            r_cmp      <= '0;
        end else if (cke_i) begin
            if (disarm_i) begin
                r_state <= ST_IDLE;
                r_irq   <= 1'b0;
            end else if (arm_i) begin
                r_state    <= ST_ARMED;
                r_irq      <= 1'b0;
                r_periodic <= cfg_periodic_i;
                r_cmp      <= cfg_cmp_i;
            end else begin
                case (r_state)
                    ST_ARMED: begin
                        if (w_match) begin
                            r_state <= ST_PENDING;
                            r_irq   <= 1'b1;
                            if (r_periodic) begin
                                if (w_period_zero) r_periodic <= 1'b0;
                                else               r_cmp      <= r_cmp + cfg_period_i;
                            end
                        end
                    end
                    ST_PENDING: begin
                        if (irq_ack_i) begin
                            r_irq   <= 1'b0;
                            r_state <= r_periodic ? ST_ARMED : ST_IDLE;
                        end else if (w_match && r_periodic) begin
                            if (w_period_zero) r_periodic <= 1'b0;
                            else               r_cmp      <= r_cmp + cfg_period_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    iob_counter_sat #(.W(MISS_W)) u_missed (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .cke_i   (cke_i),
        .clr_i   (w_miss_clr),
        .inc_i   (w_miss_inc),
        .cnt_o   (missed_o)
    );

    assign irq_o      = r_irq;
    assign state_o    = r_state;
    assign next_cmp_o = r_cmp;

endmodule
